queue_occupancy_counter: RTL and testbench
==========================================

// Module: queue_occupancy_counter
// PURPOSE
//   Parametrised customer-occupancy counter for the bank queue. Conditions two raw
//   photocell inputs (entry, exit) by synchronising, debouncing and edge-detecting
//   them. Keeps a saturating up/down count with full/empty status and sticky
//   over/underflow error flags. Feeds queue display and wait-time logic downstream.
// PARAMETERS
//   MAX_COUNT   7   capacity of the queue; count range is 0..MAX_COUNT (>=1)
//   DEB_CYCLES  4   consecutive cycles a synced input must differ from its debounced value before it flips (>=1)
//   CW          localparam = $clog2(MAX_COUNT+1), count width
// PORTS
//   clk            in   1    clock, all logic on posedge
//   rst            in   1    reset, synchronous, active-high
//   clr            in   1    sync clear of count and error flags; debouncers untouched
//   sensor_in      in   1    raw entry photocell, asynchronous, may bounce
//   sensor_out     in   1    raw exit photocell, asynchronous, may bounce
//   count          out  CW   current occupancy
//   full           out  1    count == MAX_COUNT
//   empty          out  1    count == 0
//   in_pulse       out  1    one-cycle strobe, debounced rising edge of sensor_in
//   out_pulse      out  1    one-cycle strobe, debounced rising edge of sensor_out
//   overflow_err   out  1    sticky: entry seen while full
//   underflow_err  out  1    sticky: exit seen while empty
// BEHAVIOUR
//   - Reset: count=0, empty=1, full=0, pulses=0, errors=0. Sync flops, debounced
//     values, edge regs and debounce counters are all 0.
//   - rst has priority over clr; clr has priority over pulses in the same cycle.
//   - Per sensor: 2-flop synchroniser -> debounce -> edge detect.
//     * Debounce: saturating counter of cycles where sync != deb. Any cycle with
//       sync == deb zeroes it. At DEB_CYCLES consecutive differing cycles, deb
//       takes sync and the counter zeroes.
//     * Pulse = deb & ~deb_q (deb_q is deb delayed one cycle).
//     * Latency: raw input first high at edge E gives pulse high after edge
//       E+1+DEB_CYCLES. The count changes at edge E+2+DEB_CYCLES.
//     * A glitch shorter than DEB_CYCLES synced cycles produces no pulse.
//     * Falling edges produce no pulse.
//   - Count update (one cycle after the pulse, i.e. registered on in_pulse/out_pulse):
//     * in only,  count<MAX -> count+1
//     * in only,  count==MAX -> hold, overflow_err<=1
//     * out only, count>0 -> count-1
//     * out only, count==0 -> hold, underflow_err<=1
//     * in and out same cycle -> hold, no error, at any count incl. 0 and MAX
//     * neither -> hold
//   - No wrap-around ever: count saturates at both ends.
//   - Errors stay set until rst or clr.
//   - full/empty decode the registered count combinationally; no extra latency.
//   - Reset mid-operation: any debounce in progress is discarded. A sensor held
//     high across reset deasserts is re-qualified from deb=0. It yields exactly
//     one pulse DEB_CYCLES+2 edges after rst falls.
//   - clr mid-debounce: the debounce continues. A pulse landing in the clr cycle
//     is dropped; count stays 0.
// STRUCTURE
//   - Shared package sbqm_pkg: constants DEF_MAX_COUNT, DEF_DEB_CYCLES; function
//     clog2-based width helper for CW; no typedefs needed beyond these.
//   - Sub-module sensor_conditioner (sync + debounce + rising-edge pulse,
//     parameter DEB_CYCLES), instantiated twice.
//   - Top holds only the count register, the flag decode and the error flags.
// TESTING
//   1. rst 3 cyc, release -> count=0, empty=1, full=0, errors=0, pulses=0
//   2. DEB=4: sensor_in high 10 cyc from edge E -> in_pulse one cycle after E+5; count 0->1 at E+6
//   3. sensor_in glitch high 3 cyc (DEB=4) -> no in_pulse, count unchanged
//   4. MAX=7: 8 clean entries -> count 7, full=1 after 7th; 8th sets overflow_err, count stays 7
//   5. count=0, one exit -> underflow_err=1, count 0; then clr -> errors 0
//   6. count=3, sensor_in and sensor_out rise same edge -> both pulses together, count stays 3, no errors

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared constants and width helper for the bank-queue occupancy blocks.
package sbqm_pkg;

    localparam int DEF_MAX_COUNT  = 7;
    localparam int DEF_DEB_CYCLES = 4;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sensor_conditioner.sv
// Photocell conditioning: 2-flop synchroniser, consecutive-cycle debounce,
// and a one-cycle strobe on each debounced rising edge.
module sensor_conditioner #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] TERM = DW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            // any agreeing cycle restarts qualification
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = deb & ~deb_q;

endmodule

// File: rtl/queue_occupancy_counter.sv
// Saturating queue occupancy counter driven by conditioned entry/exit
// photocells, with full/empty decode and sticky over/underflow flags.
module queue_occupancy_counter
    import sbqm_pkg::*;
#(
    parameter  int MAX_COUNT  = DEF_MAX_COUNT,
    parameter  int DEB_CYCLES = DEF_DEB_CYCLES,
    localparam int CW         = count_width(MAX_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sensor_in,
    input  logic          sensor_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          in_pulse,
    output logic          out_pulse,
    output logic          overflow_err,
    output logic          underflow_err
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_in (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_in),
        .pulse (in_pulse)
    );

    sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_out (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_out),
        .pulse (out_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            // simultaneous entry and exit cancel, even at the limits
            case ({in_pulse, out_pulse})
                2'b10: begin
                    if (count == MAX_C) overflow_err <= 1'b1;
                    else                count        <= count + 1'b1;
                end
                2'b01: begin
                    if (count == '0) underflow_err <= 1'b1;
                    else             count         <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign full  = (count == MAX_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Directed bench for queue_occupancy_counter (MAX_COUNT=7, DEB_CYCLES=4).
module tb_queue_occupancy_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       sensor_in;
    logic       sensor_out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       in_pulse;
    logic       out_pulse;
    logic       overflow_err;
    logic       underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    queue_occupancy_counter #(.MAX_COUNT(7), .DEB_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .sensor_in     (sensor_in),
        .sensor_out    (sensor_out),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .in_pulse      (in_pulse),
        .out_pulse     (out_pulse),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise the chosen sensors long enough for one clean pulse, then release
    // and let the debouncers settle low again.
    task automatic activate(input logic do_in, input logic do_out);
        sensor_in  = do_in;
        sensor_out = do_out;
        tick(7);
        sensor_in  = 1'b0;
        sensor_out = 1'b0;
        tick(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        sensor_in  = 1'b0;
        sensor_out = 1'b0;

        // reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_unf", underflow_err, 0);
        chk("rst_inp", in_pulse, 0);
        chk("rst_outp", out_pulse, 0);

        // latency: first sampled high at edge E (k=0); pulse after E+5, count at E+6
        sensor_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("lat_pulse", in_pulse, (k == 5) ? 1 : 0);
            chk("lat_count", count, (k >= 6) ? 1 : 0);
        end
        sensor_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("fall_pulse", in_pulse, 0);
            chk("fall_count", count, 1);
        end

        // 3-cycle glitch is rejected
        sensor_in = 1'b1;
        tick(3);
        sensor_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("glitch_pulse", in_pulse, 0);
            chk("glitch_count", count, 1);
            tick(1);
        end

        // fill to capacity and overflow
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_count", count, 0);
        for (int i = 1; i <= 8; i++) begin
            activate(1'b1, 1'b0);
            chk("fill_count", count, (i > 7) ? 7 : i);
            chk("fill_full", full, (i >= 7) ? 1 : 0);
            chk("fill_ovf", overflow_err, (i == 8) ? 1 : 0);
        end

        // underflow from empty, then clear
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr2_ovf", overflow_err, 0);
        chk("clr2_empty", empty, 1);
        activate(1'b0, 1'b1);
        chk("unf_flag", underflow_err, 1);
        chk("unf_count", count, 0);
        chk("unf_empty", empty, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr3_unf", underflow_err, 0);
        chk("clr3_ovf", overflow_err, 0);

        // simultaneous entry and exit at count 3
        repeat (3) activate(1'b1, 1'b0);
        chk("pre_both_count", count, 3);
        sensor_in  = 1'b1;
        sensor_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("both_inp", in_pulse, (k == 5) ? 1 : 0);
            chk("both_outp", out_pulse, (k == 5) ? 1 : 0);
            chk("both_count", count, 3);
        end
        sensor_in  = 1'b0;
        sensor_out = 1'b0;
        tick(8);
        chk("both_ovf", overflow_err, 0);
        chk("both_unf", underflow_err, 0);

        // pulse landing in a clr cycle is dropped
        sensor_in = 1'b1;
        tick(6);
        chk("clrp_pulse", in_pulse, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clrp_count", count, 0);
        tick(3);
        chk("clrp_count2", count, 0);

        // sensor held high across reset re-qualifies once
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            chk("rstq_pulse", in_pulse, (k == 6) ? 1 : 0);
            chk("rstq_count", count, (k >= 7) ? 1 : 0);
        end
        sensor_in = 1'b0;
        tick(8);
        chk("rstq_final", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
